// File: rtl/logic_pkg.sv
// logic_pkg
//   Shared definitions for the logic functional unit and its reservation
//   station: opcode encodings, operand width, the station entry layout and
//   an opcode classification helper.
package logic_pkg;

  localparam int DATA_W  = 64;
  // Entry tag fields are sized for the widest producer tag the station
  // supports; narrower tags are zero-extended on the way in.
  localparam int TAG_MAX = 8;

  localparam logic [2:0] LOP_AND  = 3'd0;
  localparam logic [2:0] LOP_XOR  = 3'd1;
  localparam logic [2:0] LOP_NAND = 3'd2;
  localparam logic [2:0] LOP_OR   = 3'd3;
  localparam logic [2:0] LOP_NOT  = 3'd4;
  localparam logic [2:0] LOP_NOR  = 3'd5;
  localparam logic [2:0] LOP_NEG  = 3'd6;
  localparam logic [2:0] LOP_XNOR = 3'd7;

  typedef struct packed {
    logic               busy;
    logic [2:0]         op;
    logic [TAG_MAX-1:0] dest;
    logic               a_rdy;
    logic [TAG_MAX-1:0] a_tag;
    logic [DATA_W-1:0]  a_val;
    logic               b_rdy;
    logic [TAG_MAX-1:0] b_tag;
    logic [DATA_W-1:0]  b_val;
  } rs_entry_t;

  function automatic logic lop_is_unary(input logic [2:0] op);
    return (op == LOP_NOT) || (op == LOP_NEG);
  endfunction

endpackage

// File: rtl/logic_unit.sv
// logic_unit
//   Combinational 64-bit logic unit.
//   op : opcode (see logic_pkg LOP_*)
//   a  : operand A
//   b  : operand B (ignored by NOT and NEG)
//   y  : result
module logic_unit
  import logic_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      LOP_AND:  y = a & b;
      LOP_XOR:  y = a ^ b;
      LOP_NAND: y = ~(a & b);
      LOP_OR:   y = a | b;
      LOP_NOT:  y = ~a;
      LOP_NOR:  y = ~(a | b);
      LOP_NEG:  y = (~a) + DATA_W'(1);
      LOP_XNOR: y = ~(a ^ b);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_rs_sched.sv
// logic_rs_sched
//   Reservation station and issue scheduler for the logic functional unit.
//   Collapsing in-order queue (slot 0 oldest) that snoops the CDB for missing
//   operands, issues the oldest ready entry into logic_unit, and holds the
//   result until the CDB arbiter accepts it.
//
//   clk, rst_n             : clock, async active-low reset
//   flush                  : synchronous squash of all entries and the result
//   disp_*                 : dispatch handshake and operand/tag fields
//   cdb_valid/tag/data     : common data bus snoop
//   res_valid/ready        : result handshake towards the CDB arbiter
//   res_tag, res_data      : held result
//   occupancy              : number of busy entries
module logic_rs_sched #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [2:0]                   disp_op,
  input  logic [TAG_W-1:0]             disp_dest,
  input  logic                         disp_a_rdy,
  input  logic                         disp_b_rdy,
  input  logic [DATA_W-1:0]            disp_a_val,
  input  logic [DATA_W-1:0]            disp_b_val,
  input  logic [TAG_W-1:0]             disp_a_tag,
  input  logic [TAG_W-1:0]             disp_b_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [TAG_W-1:0]             res_tag,
  output logic [DATA_W-1:0]            res_data,
  output logic [$clog2(ENTRIES):0]     occupancy
);

  import logic_pkg::*;

  localparam int CNT_W = $clog2(ENTRIES) + 1;
  localparam int IDX_W = $clog2(ENTRIES);

  rs_entry_t          ent [ENTRIES];
  rs_entry_t          cap [ENTRIES+1];  // extra always-empty slot feeds the top on a shift
  rs_entry_t          nxt [ENTRIES];
  rs_entry_t          disp_ent;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   wr_slot;
  logic [IDX_W-1:0]   iss_idx;
  logic               iss_found;
  logic               iss_fire;
  logic               disp_fire;
  logic [DATA_W-1:0]  lu_y;
  logic [TAG_MAX-1:0] cdb_tag_x;

  function automatic rs_entry_t snoop(input rs_entry_t e,
                                      input logic v,
                                      input logic [TAG_MAX-1:0] t,
                                      input logic [DATA_W-1:0] d);
    rs_entry_t r;
    r = e;
    if (e.busy && !e.a_rdy && v && (e.a_tag == t)) begin
      r.a_rdy = 1'b1;
      r.a_val = d;
    end
    if (e.busy && !e.b_rdy && v && (e.b_tag == t)) begin
      r.b_rdy = 1'b1;
      r.b_val = d;
    end
    return r;
  endfunction

  assign cdb_tag_x  = TAG_MAX'(cdb_tag);
  assign disp_ready = (cnt < CNT_W'(ENTRIES));
  assign disp_fire  = disp_valid && disp_ready;
  assign occupancy  = cnt;

  // Incoming entry, already snooped so a same-cycle broadcast is not missed.
  always_comb begin
    rs_entry_t d;
    d       = '0;
    d.busy  = 1'b1;
    d.op    = disp_op;
    d.dest  = TAG_MAX'(disp_dest);
    d.a_rdy = disp_a_rdy;
    d.a_tag = TAG_MAX'(disp_a_tag);
    d.a_val = disp_a_val;
    d.b_rdy = disp_b_rdy || lop_is_unary(disp_op);
    d.b_tag = TAG_MAX'(disp_b_tag);
    d.b_val = disp_b_val;
    disp_ent = snoop(d, cdb_valid, cdb_tag_x, cdb_data);
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      cap[i] = snoop(ent[i], cdb_valid, cdb_tag_x, cdb_data);
    end
    cap[ENTRIES] = '0;
  end

  // Oldest ready entry wins; readiness is the registered state, so a value
  // captured this cycle issues on the following edge.
  always_comb begin
    iss_found = 1'b0;
    iss_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].busy && ent[i].a_rdy && ent[i].b_rdy) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
  end

  assign iss_fire = iss_found && (!res_valid || res_ready);
  assign wr_slot  = iss_fire ? (cnt - CNT_W'(1)) : cnt;
  assign cnt_nxt  = cnt + CNT_W'(disp_fire) - CNT_W'(iss_fire);

  // Collapse above the issued slot, then drop the dispatch into the first
  // free slot of the collapsed queue (always an empty position).
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (iss_fire && (i >= int'(iss_idx))) nxt[i] = cap[i+1];
      else                                  nxt[i] = cap[i];
      if (disp_fire && (CNT_W'(i) == wr_slot)) nxt[i] = disp_ent;
    end
  end

  logic_unit u_lu (
    .op (ent[iss_idx].op),
    .a  (ent[iss_idx].a_val),
    .b  (ent[iss_idx].b_val),
    .y  (lu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= nxt[i];
      cnt <= cnt_nxt;
      if (iss_fire) begin
        res_valid <= 1'b1;
        res_tag   <= ent[iss_idx].dest[TAG_W-1:0];
        res_data  <= lu_y;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_rs_sched.sv
// tb_logic_rs_sched
//   Directed bench for logic_rs_sched with hand-computed expectations.
module tb_logic_rs_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_op;
  logic [3:0]  disp_dest;
  logic        disp_a_rdy, disp_b_rdy;
  logic [63:0] disp_a_val, disp_b_val;
  logic [3:0]  disp_a_tag, disp_b_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_tag;
  logic [63:0] res_data;
  logic [2:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  logic_rs_sched #(.ENTRIES(4), .TAG_W(4), .DATA_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_op    (disp_op),
    .disp_dest  (disp_dest),
    .disp_a_rdy (disp_a_rdy),
    .disp_b_rdy (disp_b_rdy),
    .disp_a_val (disp_a_val),
    .disp_b_val (disp_b_val),
    .disp_a_tag (disp_a_tag),
    .disp_b_tag (disp_b_tag),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_tag    (res_tag),
    .res_data   (res_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [2:0] op, input logic [3:0] dest,
                      input logic ar, input logic [63:0] av, input logic [3:0] at,
                      input logic br, input logic [63:0] bv, input logic [3:0] bt);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_dest  = dest;
    disp_a_rdy = ar;
    disp_a_val = av;
    disp_a_tag = at;
    disp_b_rdy = br;
    disp_b_val = bv;
    disp_b_tag = bt;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [63:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1;
    disp_valid = 1'b0; disp_op = '0; disp_dest = '0;
    disp_a_rdy = 1'b0; disp_b_rdy = 1'b0; disp_a_val = '0; disp_b_val = '0;
    disp_a_tag = '0; disp_b_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    #3;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_tag",   64'(res_tag),   64'd0);
    chk("rst_res_data",  res_data,       64'd0);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_disp_rdy",  64'(disp_ready), 64'd1);
    #9 rst_n = 1'b1;
    step();

    // AND, both ready
    disp(3'd0, 4'd3, 1'b1, 64'hF0F0, 4'd0, 1'b1, 64'h0FF0, 4'd0);
    step(); idle();
    chk("and_occ1",   64'(occupancy), 64'd1);
    chk("and_noval",  64'(res_valid), 64'd0);
    step();
    chk("and_valid",  64'(res_valid), 64'd1);
    chk("and_data",   res_data,       64'h00F0);
    chk("and_tag",    64'(res_tag),   64'd3);
    chk("and_occ0",   64'(occupancy), 64'd0);
    step();
    chk("and_drain",  64'(res_valid), 64'd0);

    // NEG, B not awaited
    disp(3'd6, 4'd4, 1'b1, 64'd1, 4'd0, 1'b0, 64'd0, 4'd9);
    step(); idle();
    step();
    chk("neg_valid",  64'(res_valid), 64'd1);
    chk("neg_data",   res_data,       64'hFFFF_FFFF_FFFF_FFFF);
    chk("neg_tag",    64'(res_tag),   64'd4);
    step();

    // XOR waiting on tag 5, broadcast a cycle later
    disp(3'd1, 4'd6, 1'b0, 64'd0, 4'd5, 1'b1, 64'h10, 4'd0);
    step(); idle();
    chk("xor_occ",    64'(occupancy), 64'd1);
    bcast(4'd5, 64'h3);
    step(); cdb_valid = 1'b0;
    chk("xor_cap_noval", 64'(res_valid), 64'd0);
    step();
    chk("xor_valid",  64'(res_valid), 64'd1);
    chk("xor_data",   res_data,       64'h13);
    chk("xor_tag",    64'(res_tag),   64'd6);
    // same op, broadcast in the dispatch cycle
    disp(3'd1, 4'd6, 1'b0, 64'd0, 4'd5, 1'b1, 64'h10, 4'd0);
    bcast(4'd5, 64'h3);
    step(); idle(); cdb_valid = 1'b0;
    chk("xor2_noval", 64'(res_valid), 64'd0);
    chk("xor2_occ",   64'(occupancy), 64'd1);
    step();
    chk("xor2_valid", 64'(res_valid), 64'd1);
    chk("xor2_data",  res_data,       64'h13);
    step();

    // Fill with res_ready low, then drain in order
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(3'd3, 4'(k + 1), 1'b1, 64'h1000 + 64'(k), 4'd0, 1'b1, 64'h200, 4'd0);
      step();
    end
    chk("fill_occ3",  64'(occupancy), 64'd3);
    chk("fill_valid", 64'(res_valid), 64'd1);
    chk("fill_drdy1", 64'(disp_ready), 64'd1);
    chk("fill_data0", res_data,       64'h1200);
    disp(3'd3, 4'd5, 1'b1, 64'h1004, 4'd0, 1'b1, 64'h200, 4'd0);
    step(); idle();
    chk("fill_occ4",  64'(occupancy), 64'd4);
    chk("fill_drdy0", 64'(disp_ready), 64'd0);
    chk("fill_hold",  res_data,       64'h1200);
    chk("fill_htag",  64'(res_tag),   64'd1);
    res_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("drain_data", res_data,     64'h1200 + 64'(k));
      chk("drain_tag",  64'(res_tag), 64'(k + 1));
      chk("drain_vld",  64'(res_valid), 64'd1);
    end
    chk("drain_occ0", 64'(occupancy), 64'd0);
    step();
    chk("drain_end",  64'(res_valid), 64'd0);

    // Younger ready entry bypasses a waiting slot 0
    disp(3'd0, 4'd7, 1'b0, 64'd0, 4'd2, 1'b1, 64'hFF, 4'd0);
    step();
    disp(3'd1, 4'd8, 1'b1, 64'hA, 4'd0, 1'b1, 64'h5, 4'd0);
    step(); idle();
    chk("byp_occ2",   64'(occupancy), 64'd2);
    chk("byp_noval",  64'(res_valid), 64'd0);
    bcast(4'd2, 64'h1234);
    step(); cdb_valid = 1'b0;
    chk("byp_tag1",   64'(res_tag),   64'd8);
    chk("byp_data1",  res_data,       64'hF);
    chk("byp_occ1",   64'(occupancy), 64'd1);
    step();
    chk("byp_tag0",   64'(res_tag),   64'd7);
    chk("byp_data0",  res_data,       64'h34);
    chk("byp_occ0",   64'(occupancy), 64'd0);
    step();

    // Capture into an entry that shifts down in the same cycle
    res_ready = 1'b0;
    disp(3'd3, 4'd11, 1'b1, 64'h1, 4'd0, 1'b1, 64'h2, 4'd0);
    step();
    disp(3'd1, 4'd12, 1'b1, 64'hFF, 4'd0, 1'b1, 64'h0F, 4'd0);
    step();
    disp(3'd0, 4'd13, 1'b0, 64'd0, 4'd3, 1'b1, 64'hF0, 4'd0);
    step(); idle();
    chk("shf_occ2",   64'(occupancy), 64'd2);
    chk("shf_hold",   res_data,       64'h3);
    res_ready = 1'b1;
    bcast(4'd3, 64'h3C);
    step(); cdb_valid = 1'b0;
    chk("shf_data1",  res_data,       64'hF0);
    chk("shf_tag1",   64'(res_tag),   64'd12);
    step();
    chk("shf_data2",  res_data,       64'h30);
    chk("shf_tag2",   64'(res_tag),   64'd13);
    chk("shf_occ0",   64'(occupancy), 64'd0);
    step();

    // Flush with a dispatch in the same cycle
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(3'd3, 4'(k + 1), 1'b1, 64'h1000 + 64'(k), 4'd0, 1'b1, 64'h200, 4'd0);
      step();
    end
    chk("fl_pre_occ", 64'(occupancy), 64'd3);
    chk("fl_pre_vld", 64'(res_valid), 64'd1);
    flush = 1'b1;
    step(); flush = 1'b0; idle();
    chk("fl_occ",     64'(occupancy), 64'd0);
    chk("fl_vld",     64'(res_valid), 64'd0);
    chk("fl_drdy",    64'(disp_ready), 64'd1);
    step();
    chk("fl_stay",    64'(res_valid), 64'd0);

    // Asynchronous reset mid-stream
    disp(3'd0, 4'd3, 1'b1, 64'hF0F0, 4'd0, 1'b1, 64'h0FF0, 4'd0);
    step();
    disp(3'd3, 4'd9, 1'b1, 64'h1, 4'd0, 1'b1, 64'h2, 4'd0);
    step(); idle();
    chk("ar_pre_vld", 64'(res_valid), 64'd1);
    chk("ar_pre_occ", 64'(occupancy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld",     64'(res_valid), 64'd0);
    chk("ar_tag",     64'(res_tag),   64'd0);
    chk("ar_data",    res_data,       64'd0);
    chk("ar_occ",     64'(occupancy), 64'd0);
    chk("ar_drdy",    64'(disp_ready), 64'd1);
    #10 rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_rs_sched.md
# logic_rs_sched

Reservation station and issue scheduler for the 64-bit logic functional unit in the Tomasulo core. Holds up to `ENTRIES` dispatched logic ops, snoops the common data bus (CDB) for missing operands, and issues the oldest ready op to an internal `logic_unit`. Each result is held in an output register until the CDB arbiter grants it.

## Interface
- `ENTRIES`, 4: station depth, ≥2.
- `TAG_W`, 4: ROB/producer tag width.
- `DATA_W`, 64: operand width; fixed at 64 to match `logic_unit`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous squash of all state.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: entry available; dispatch fires on `disp_valid & disp_ready`.
- `disp_op` in 3: logic opcode 0..7.
- `disp_dest` in TAG_W: tag of the result.
- `disp_a_rdy`, `disp_b_rdy` in 1: operand value present.
- `disp_a_val`, `disp_b_val` in 64: operand values, valid when rdy.
- `disp_a_tag`, `disp_b_tag` in TAG_W: producer tags, used when not rdy.
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in 64: broadcast snoop.
- `res_valid` out 1: result held for the CDB.
- `res_ready` in 1: CDB grant; transfer on `res_valid & res_ready`.
- `res_tag` out TAG_W, `res_data` out 64: held result.
- `occupancy` out $clog2(ENTRIES)+1: busy entry count.

## Operation
- Opcodes: 0 AND, 1 XOR, 2 NAND, 3 OR, 4 NOT a, 5 NOR, 6 NEG a (two's complement), 7 XNOR.
- Ops 4 and 6 are unary. Operand B is marked ready at dispatch regardless of `disp_b_rdy`.
- The station is a collapsing in-order queue. Slot 0 is the oldest. Dispatch writes slot `occupancy`, or `occupancy-1` when an issue happens in the same cycle.
- `disp_ready = (occupancy < ENTRIES)`. A same-cycle issue does not create a free slot.
- CDB capture: every busy, not-ready operand whose tag equals `cdb_tag` while `cdb_valid` is high takes `cdb_data` and becomes ready.
- Capture also applies to a dispatching operand whose tag matches in the same cycle.
- Capture also applies to entries that are shifting down in the same cycle.
- Issue selects the lowest-index entry with both operands ready.
- An issue fires when the output register is empty or is transferring this cycle.
- The issued entry is removed, higher entries shift down one slot, and the `logic_unit` result is loaded into `res_data`/`res_tag`.
- Dispatch, capture, issue and result transfer can all happen in one cycle. The block must produce a consistent queue in that case.
- Flush has priority over everything else. On the next edge it clears all entries and `res_valid`, and the dispatch in that cycle is dropped.
- An operand that is never broadcast leaves its entry waiting indefinitely. Younger ready entries still issue past it.

## Timing
- Reset values:
  - `res_valid` = 0.
  - `res_tag` = 0.
  - `res_data` = 0.
  - `occupancy` = 0.
  - `disp_ready` = 1.
  - All entries invalid.
- Latency from dispatch with both operands ready to `res_valid` high is 2 edges: one to enter the station, one to issue.
- Latency from a CDB broadcast completing the last operand to `res_valid` high is 1 edge after capture, i.e. 2 edges from the broadcast.
- Throughput is one issue per cycle while `res_ready` is held high.
- Once asserted, `res_valid`, `res_tag` and `res_data` stay stable until the transfer or a flush.
- Asserting `rst_n` mid-operation clears all state immediately, without waiting for a clock edge.

## Structure
- `logic_pkg` holds:
  - opcode localparams `LOP_AND` … `LOP_XNOR`;
  - `DATA_W = 64`;
  - the entry struct: busy, op, dest, a_rdy/a_tag/a_val, b_rdy/b_tag/b_val;
  - the function `lop_is_unary`.
- Sub-module: one instance of the existing combinational `logic_unit`, which computes the issue-slot result. The scheduler contains no other compute logic.

## Test plan
- Dispatch AND with a=0xF0F0, b=0x0FF0, both ready, `res_ready`=1 → `res_valid` 2 edges later with `res_data`=0x00F0 and the dispatched tag; `occupancy` returns to 0.
- Dispatch NEG with a=1, `disp_b_rdy`=0 → `res_data`=0xFFFF_FFFF_FFFF_FFFF; B is not awaited.
- Dispatch XOR with a waiting on tag 5. Broadcast tag 5, data 0x3 → `res_data`=0x3^b one edge after capture. Repeat with the broadcast in the same cycle as dispatch → identical result.
- Fill 4 entries, then hold `res_ready`=0 with all entries ready → one result held, `occupancy`=3, `disp_ready`=1. A 5th dispatch fills the station and `disp_ready` drops to 0. Release `res_ready` → results come out in dispatch order.
- Slot 0 waiting on tag 2, slot 1 ready → slot 1 issues first. Broadcast tag 2 during the shift → the old slot-0 entry issues next with the captured value.
- Flush with 3 entries busy and `res_valid`=1 → next cycle `occupancy`=0 and `res_valid`=0. Assert `rst_n`=0 asynchronously mid-stream → outputs reach their reset values before the next edge.
